fdc_averager: RTL and testbench
===============================

FDC_AVERAGER -- requirements
Module: fdc_averager

Interface
REQ-001 SHALL have parameter LOG2_N, default 4, meaning log2 of the averaging window (legal range 1..8).
REQ-002 SHALL have parameter DATA_W, default 5, meaning the FDC code width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: accumulation enable.
REQ-006 SHALL have port in_code, input, DATA_W bits: FDC count sample, already synchronous to clk.
REQ-007 SHALL have port in_valid, input, 1 bit: in_code is valid this cycle.
REQ-008 SHALL have port out_code, output, DATA_W bits: rounded window average.
REQ-009 SHALL have port out_valid, output, 1 bit: out_code holds an unconsumed result.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts out_code.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag, set when a result was lost.
REQ-012 SHALL have port clear_overrun, input, 1 bit: clears overrun.

Function
REQ-013 SHALL accept a sample only on a cycle where enable=1 and in_valid=1.
REQ-014 SHALL accumulate accepted samples in an accumulator of DATA_W+LOG2_N bits, with a sample counter of LOG2_N bits.
REQ-015 SHALL complete a window on the 2^LOG2_N-th accepted sample.
REQ-016 SHALL compute the result as (sum + 2^(LOG2_N-1)) >> LOG2_N; the result never exceeds 2^DATA_W-1, so no saturation logic is required.
REQ-017 SHALL register the result, with out_valid rising exactly one cycle after the completing sample.
REQ-018 SHALL restart the window on the cycle after completion: the completing sample is excluded from the next window and no sample is lost.
REQ-019 SHALL clear out_valid, on a cycle where out_valid=1 and out_ready=1, on the next edge unless a new result completes in that same cycle.
REQ-020 SHALL hold out_code stable while out_valid=1 and out_ready=0.
REQ-021 SHALL discard the new result when a window completes while out_valid=1 and out_ready=0; out_code is kept and overrun is set.
REQ-022 SHALL, when a window completes while out_valid=1 and out_ready=1, load the new result, keep out_valid=1 and leave overrun unchanged.
REQ-023 SHALL, when enable=0, zero the accumulator and counter next cycle; a pending out_valid/out_code is retained.
REQ-024 SHALL give set priority over clear_overrun when both act in the same cycle.
REQ-025 SHALL implement an FSM with these states and transitions:
- IDLE to ACCUM when enable=1.
- ACCUM to IDLE when enable=0.
- ACCUM stays in ACCUM across window completions.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, set state=IDLE, accumulator=0, counter=0, out_code=0, out_valid=0 and overrun=0.
REQ-027 SHALL give reset precedence over all other inputs; a partial window is discarded on reset mid-operation.

Configuration
REQ-028 SHALL, with macro FDC_AVG_MINMAX_EN defined, add outputs out_min and out_max (DATA_W bits each):
- They hold the minimum and maximum sample of the window that produced out_code.
- They update together with out_code.
- Their reset values are all-ones and 0 respectively.
REQ-029 SHALL, without FDC_AVG_MINMAX_EN, omit those ports and their logic entirely.

Structure
REQ-030 SHALL place DATA_W default, the fdc_code_t typedef and the FSM state enum in shared package fdc_pkg.
REQ-031 SHALL place min/max tracking in sub-module fdc_minmax, instantiated only under FDC_AVG_MINMAX_EN.

Verification
REQ-032 SHALL cover: enable=1, 16 samples of code 10 with out_ready=1 -> out_code=10, out_valid high one cycle after the 16th sample.
REQ-033 SHALL cover: 8 samples of 3 and 8 samples of 4 -> sum 56, out_code=(56+8)>>4=4.
REQ-034 SHALL cover: 16 samples of 31 -> out_code=31 with no wrap.
REQ-035 SHALL cover: out_ready=0 across two completed windows (avg 5, then avg 9) -> out_code stays 5 and overrun=1; then clear_overrun -> overrun=0.
REQ-036 SHALL cover: reset asserted after 7 samples, then 16 samples of 2 -> out_code=2, confirming no residue from the aborted window.
REQ-037 SHALL cover: with FDC_AVG_MINMAX_EN, window samples 0..15 -> out_min=0, out_max=15, out_code=8.

Source files
------------

// File: rtl/fdc_pkg.sv
// Shared definitions for the FDC averager: default code width, code type
// and the control FSM state encoding.
package fdc_pkg;

  localparam int FDC_DATA_W = 5;

  typedef logic [FDC_DATA_W-1:0] fdc_code_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } fdc_state_e;

endpackage

// File: rtl/fdc_minmax.sv
// Per-window min/max tracker for the FDC averager; its outputs update together
// with out_code. Only instantiated when FDC_AVG_MINMAX_EN is defined.
module fdc_minmax
  import fdc_pkg::*;
#(
  parameter int DATA_W = FDC_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_sample,
  input  logic              i_done,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_code,
  output logic [DATA_W-1:0] o_min,
  output logic [DATA_W-1:0] o_max
);

  logic [DATA_W-1:0] r_run_min;
  logic [DATA_W-1:0] r_run_max;
  logic [DATA_W-1:0] r_min;
  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] w_min;
  logic [DATA_W-1:0] w_max;

  // The completing sample belongs to the finished window, so fold it in combinationally.
  assign w_min = (i_code < r_run_min) ? i_code : r_run_min;
  assign w_max = (i_code > r_run_max) ? i_code : r_run_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_min <= '1;
      r_run_max <= '0;
      r_min     <= '1;
      r_max     <= '0;
    end else begin
      if (i_clear || i_done) begin
        r_run_min <= '1;
        r_run_max <= '0;
      end else if (i_sample) begin
        r_run_min <= w_min;
        r_run_max <= w_max;
      end
      if (i_done && i_load) begin
        r_min <= w_min;
        r_max <= w_max;
      end
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;

endmodule

// File: rtl/fdc_averager.sv
// Windowed, round-half-up averager for FDC codes with a one-deep output register
// and sticky overrun flag. FDC_AVG_MINMAX_EN adds per-window out_min/out_max.
//
// state    | meaning
// ST_IDLE  | enable low; accumulator and counter held at zero
// ST_ACCUM | enable high; accepting samples, windows roll over back to back
module fdc_averager
  import fdc_pkg::*;
#(
  parameter int LOG2_N = 4,
  parameter int DATA_W = FDC_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_code,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              clear_overrun
`ifdef FDC_AVG_MINMAX_EN
  ,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max
`endif
);

  localparam int              ACC_W = DATA_W + LOG2_N;
  localparam logic [ACC_W-1:0] RND  = ACC_W'(1) << (LOG2_N - 1);

  fdc_state_e        r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [LOG2_N-1:0] r_cnt;
  logic [DATA_W-1:0] r_out_code;
  logic              r_out_valid;
  logic              r_overrun;

  logic              w_accept;
  logic              w_done;
  logic              w_load;
  logic [ACC_W-1:0]  w_sum;

  assign w_accept = enable & in_valid;
  assign w_done   = w_accept & (r_cnt == '1);
  assign w_sum    = r_acc + ACC_W'(in_code);
  // A finished window may replace the result only if the old one is gone or leaving now.
  assign w_load   = w_done & (~r_out_valid | out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_code  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:  if (enable) r_state <= ST_ACCUM;
        ST_ACCUM: if (!enable) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase

      if (!enable || w_done) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + LOG2_N'(1);
      end

      if (w_load) begin
        r_out_code  <= DATA_W'((w_sum + RND) >> LOG2_N);
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_done && r_out_valid && !out_ready) begin
        r_overrun <= 1'b1;
      end else if (clear_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign out_code  = r_out_code;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

`ifdef FDC_AVG_MINMAX_EN
  fdc_minmax #(
    .DATA_W (DATA_W)
  ) u_minmax (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (~enable),
    .i_sample (w_accept),
    .i_done   (w_done),
    .i_load   (w_load),
    .i_code   (in_code),
    .o_min    (out_min),
    .o_max    (out_max)
  );
`endif

endmodule

// File: tb/tb_fdc_averager.sv
// Directed bench for fdc_averager: a table of two-half windows plus hand-written
// overrun/reset/enable sequences; min/max checks when FDC_AVG_MINMAX_EN is defined.
module tb_fdc_averager;
  import fdc_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      enable;
  fdc_code_t in_code;
  logic      in_valid;
  fdc_code_t out_code;
  logic      out_valid;
  logic      out_ready;
  logic      overrun;
  logic      clear_overrun;
`ifdef FDC_AVG_MINMAX_EN
  fdc_code_t out_min;
  fdc_code_t out_max;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fdc_averager #(
    .LOG2_N (4),
    .DATA_W (FDC_DATA_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .in_code       (in_code),
    .in_valid      (in_valid),
    .out_code      (out_code),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
`ifdef FDC_AVG_MINMAX_EN
    ,
    .out_min       (out_min),
    .out_max       (out_max)
`endif
  );

  typedef struct {
    fdc_code_t a;
    fdc_code_t b;
    fdc_code_t exp_code;
  } win_vec_t;

  win_vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_n(input int n, input fdc_code_t code);
    for (int i = 0; i < n; i++) begin
      in_code  = code;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // 8 samples of a followed by 8 of b; expected = (8a + 8b + 8) >> 4
    vecs[0] = '{5'd10, 5'd10, 5'd10};
    vecs[1] = '{5'd3,  5'd4,  5'd4};
    vecs[2] = '{5'd31, 5'd31, 5'd31};
    vecs[3] = '{5'd0,  5'd0,  5'd0};
    vecs[4] = '{5'd0,  5'd1,  5'd1};
    vecs[5] = '{5'd1,  5'd2,  5'd2};
    vecs[6] = '{5'd2,  5'd3,  5'd3};
    vecs[7] = '{5'd0,  5'd31, 5'd16};
    vecs[8] = '{5'd7,  5'd8,  5'd8};
    vecs[9] = '{5'd1,  5'd0,  5'd1};

    reset         = 1'b1;
    enable        = 1'b0;
    in_code       = '0;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    clear_overrun = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_valid",   32'(out_valid), 0);
    check("rst_code",    32'(out_code),  0);
    check("rst_overrun", 32'(overrun),   0);
`ifdef FDC_AVG_MINMAX_EN
    check("rst_min", 32'(out_min), 31);
    check("rst_max", 32'(out_max), 0);
`endif

    enable    = 1'b1;
    out_ready = 1'b1;
    for (int v = 0; v < 10; v++) begin
      send_n(8, vecs[v].a);
      send_n(7, vecs[v].b);
      check($sformatf("win%0d_early", v), 32'(out_valid), 0);
      send_n(1, vecs[v].b);
      check($sformatf("win%0d_valid", v), 32'(out_valid), 1);
      check($sformatf("win%0d_code", v),  32'(out_code),  32'(vecs[v].exp_code));
      step();
      check($sformatf("win%0d_taken", v), 32'(out_valid), 0);
    end
    check("table_overrun", 32'(overrun), 0);

    // Lost result: out_code stays at the first average, overrun sticks until cleared.
    out_ready = 1'b0;
    send_n(16, 5'd5);
    check("ovr_first_code", 32'(out_code), 5);
    send_n(16, 5'd9);
    check("ovr_hold_code",  32'(out_code),  5);
    check("ovr_hold_valid", 32'(out_valid), 1);
    check("ovr_set",        32'(overrun),   1);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("ovr_cleared",    32'(overrun),   0);
    check("ovr_code_after", 32'(out_code),  5);
    out_ready = 1'b1;
    step();
    check("ovr_consumed",   32'(out_valid), 0);

    // Completion in the same cycle the old result is taken: new result replaces it.
    out_ready = 1'b0;
    send_n(16, 5'd6);
    send_n(15, 5'd12);
    out_ready = 1'b1;
    send_n(1, 5'd12);
    check("swap_code",    32'(out_code),  12);
    check("swap_valid",   32'(out_valid), 1);
    check("swap_overrun", 32'(overrun),   0);
    step();
    check("swap_taken",   32'(out_valid), 0);

    // Overrun set wins over a simultaneous clear.
    out_ready = 1'b0;
    send_n(16, 5'd1);
    send_n(15, 5'd3);
    clear_overrun = 1'b1;
    send_n(1, 5'd3);
    clear_overrun = 1'b0;
    check("prio_overrun", 32'(overrun),  1);
    check("prio_code",    32'(out_code), 1);
    clear_overrun = 1'b1;
    out_ready     = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("prio_cleared", 32'(overrun), 0);

    // enable low mid-window: partial sum dropped, pending result retained.
    out_ready = 1'b0;
    send_n(16, 5'd7);
    send_n(5, 5'd31);
    enable   = 1'b0;
    in_code  = 5'd31;
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    check("dis_valid_kept", 32'(out_valid), 1);
    check("dis_code_kept",  32'(out_code),  7);
    enable    = 1'b1;
    out_ready = 1'b1;
    step();
    send_n(16, 5'd2);
    check("dis_restart_code",  32'(out_code),  2);
    check("dis_restart_valid", 32'(out_valid), 1);
    step();

    // Reset mid-window, then a gapped window of 2s.
    send_n(7, 5'd31);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_code",  32'(out_code),  0);
    for (int i = 0; i < 15; i++) begin
      send_n(1, 5'd2);
      step();
    end
    check("gap_early", 32'(out_valid), 0);
    send_n(1, 5'd2);
    check("rst_clean_code",  32'(out_code),  2);
    check("rst_clean_valid", 32'(out_valid), 1);
    step();

`ifdef FDC_AVG_MINMAX_EN
    for (int i = 0; i < 16; i++) begin
      send_n(1, fdc_code_t'(i));
    end
    check("mm_code", 32'(out_code), 8);
    check("mm_min",  32'(out_min),  0);
    check("mm_max",  32'(out_max),  15);
    step();
    send_n(16, 5'd9);
    check("mm2_min", 32'(out_min), 9);
    check("mm2_max", 32'(out_max), 9);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
